// File: rtl/riscv_crypto_sm4_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_crypto_sm4_pkg
// Brief    : Shared types and constants for the SM4 round functional unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_crypto_sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sm4_state_e;

  // Encrypt/decrypt linear layer, byte-local form: wrapped bits of l<<26 / l<<10
  localparam logic [31:0] c_ED_MASK_A  = 32'h0000_003F;
  localparam int unsigned c_ED_SHIFT_A = 26;
  localparam logic [31:0] c_ED_MASK_B  = 32'h0000_00C0;
  localparam int unsigned c_ED_SHIFT_B = 10;

  // Key-schedule linear layer, byte-local form
  localparam logic [31:0] c_KS_MASK_A  = 32'h0000_0007;
  localparam int unsigned c_KS_SHIFT_A = 29;
  localparam logic [31:0] c_KS_MASK_B  = 32'h0000_00FE;
  localparam int unsigned c_KS_SHIFT_B = 7;
  localparam logic [31:0] c_KS_MASK_C  = 32'h0000_0001;
  localparam int unsigned c_KS_SHIFT_C = 23;
  localparam logic [31:0] c_KS_MASK_D  = 32'h0000_00F8;
  localparam int unsigned c_KS_SHIFT_D = 13;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_crypto_sm4_lane.sv
//------------------------------------------------------------------------------
// Module   : riscv_crypto_sm4_lane
// Brief    : One S-box lane: substitute a byte, apply L or L', rotate into place.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_crypto_sm4_lane
  import riscv_crypto_sm4_pkg::*;
(
  input  logic [7:0]  byte_in,
  input  logic [1:0]  byte_idx,
  input  logic        op_ks,
  output logic [31:0] contrib
);

  logic [7:0]  w_sbox_out;
  logic [31:0] w_l;
  logic [31:0] w_ed;
  logic [31:0] w_ks;
  logic [31:0] w_lin;

  riscv_crypto_sm4_sbox u_sbox (
    .sbox_in  (byte_in),
    .sbox_out (w_sbox_out)
  );

  assign w_l  = {24'b0, w_sbox_out};

  assign w_ed = w_l ^ (w_l << 8) ^ (w_l << 2) ^ (w_l << 18)
              ^ ((w_l & c_ED_MASK_A) << c_ED_SHIFT_A)
              ^ ((w_l & c_ED_MASK_B) << c_ED_SHIFT_B);

  assign w_ks = w_l
              ^ ((w_l & c_KS_MASK_A) << c_KS_SHIFT_A)
              ^ ((w_l & c_KS_MASK_B) << c_KS_SHIFT_B)
              ^ ((w_l & c_KS_MASK_C) << c_KS_SHIFT_C)
              ^ ((w_l & c_KS_MASK_D) << c_KS_SHIFT_D);

  assign w_lin = op_ks ? w_ks : w_ed;

  // Rotate left by 8*byte_idx so the contribution lands on its byte lane
  always_comb begin
    contrib = w_lin;
    case (byte_idx)
      2'd0: contrib = w_lin;
      2'd1: contrib = {w_lin[23:0], w_lin[31:24]};
      2'd2: contrib = {w_lin[15:0], w_lin[31:16]};
      2'd3: contrib = {w_lin[7:0],  w_lin[31:8]};
      default: contrib = w_lin;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_crypto_sm4_sbox.sv
//------------------------------------------------------------------------------
// Module   : riscv_crypto_sm4_sbox
// Brief    : Combinational SM4 8-bit substitution box (table lookup).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_crypto_sm4_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  localparam logic [0:255][7:0] c_SBOX_TAB = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign sbox_out = c_SBOX_TAB[sbox_in];

endmodule

`default_nettype wire

// File: rtl/riscv_crypto_fu_sm4_round.sv
//------------------------------------------------------------------------------
// Module   : riscv_crypto_fu_sm4_round
// Brief    : Multi-cycle SM4 T / T' round unit, LANES bytes per cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module riscv_crypto_fu_sm4_round
  import riscv_crypto_sm4_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int REG_OUT = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        op_ks,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  if (!lanes_legal(LANES) || (REG_OUT != 1)) begin : g_bad_param
    $error("riscv_crypto_fu_sm4_round: LANES must be 1/2/4 and REG_OUT must be 1");
  end

  localparam logic [2:0] c_LANES3 = 3'(LANES);

  sm4_state_e  r_state;
  sm4_state_e  w_state_next;
  logic [1:0]  r_ctr;
  logic [31:0] r_acc;
  logic [31:0] r_rs2;
  logic        r_op_ks;
  logic [31:0] r_result;
  logic [31:0] w_acc_next;
  logic [2:0]  w_ctr_next;
  logic        w_last;
  logic [31:0] w_contrib [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [1:0] w_idx;
    assign w_idx = r_ctr + 2'(j);
    riscv_crypto_sm4_lane u_lane (
      .byte_in  (r_rs2[8*w_idx +: 8]),
      .byte_idx (w_idx),
      .op_ks    (r_op_ks),
      .contrib  (w_contrib[j])
    );
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < LANES; j++) begin
      w_acc_next = w_acc_next ^ w_contrib[j];
    end
  end

  // 3-bit sum so the final step reaching byte 4 is visible without wrapping
  assign w_ctr_next = {1'b0, r_ctr} + c_LANES3;
  assign w_last     = (w_ctr_next == 3'd4);

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) w_state_next = ST_BUSY;
        ST_BUSY: if (w_last)   w_state_next = ST_DONE;
        ST_DONE: if (out_ready) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_ctr    <= 2'd0;
      r_acc    <= 32'd0;
      r_rs2    <= 32'd0;
      r_op_ks  <= 1'b0;
      r_result <= 32'd0;
    end else if (flush) begin
      r_ctr <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_acc   <= rs1;
          r_rs2   <= rs2;
          r_op_ks <= op_ks;
          r_ctr   <= 2'd0;
        end
        ST_BUSY: begin
          r_acc <= w_acc_next;
          r_ctr <= w_ctr_next[1:0];
          if (w_last) r_result <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_riscv_crypto_fu_sm4_round.sv
//------------------------------------------------------------------------------
// Module   : tb_riscv_crypto_fu_sm4_round
// Brief    : Self-checking bench for the SM4 round unit at LANES = 1, 2 and 4.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_riscv_crypto_fu_sm4_round;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        op_ks;
  logic [2:0]  in_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [31:0] result_v [3];

  int errors = 0;
  int checks = 0;
  int lanes_of [3] = '{1, 2, 4};

  logic [0:255][7:0] sbox_tab = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  always #5 g_clk = ~g_clk;

  riscv_crypto_fu_sm4_round #(.LANES(1), .REG_OUT(1)) u_dut1 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .rs1(rs1), .rs2(rs2), .op_ks(op_ks),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .result(result_v[0])
  );

  riscv_crypto_fu_sm4_round #(.LANES(2), .REG_OUT(1)) u_dut2 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .rs1(rs1), .rs2(rs2), .op_ks(op_ks),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .result(result_v[1])
  );

  riscv_crypto_fu_sm4_round #(.LANES(4), .REG_OUT(1)) u_dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .rs1(rs1), .rs2(rs2), .op_ks(op_ks),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .result(result_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
  endfunction

  // Single-byte-select instruction: rs1 ^ rotl(L(sbox(rs2.byte[bs])), 8*bs)
  function automatic logic [31:0] bs_step(input logic [31:0] a, input logic [31:0] b,
                                          input int bs, input logic ks);
    logic [31:0] x;
    logic [31:0] lin;
    x = {24'b0, sbox_tab[b[8*bs +: 8]]};
    if (!ks)
      lin = x ^ (x << 8) ^ (x << 2) ^ (x << 18) ^ ((x & 32'h3F) << 26) ^ ((x & 32'hC0) << 10);
    else
      lin = x ^ ((x & 32'h7) << 29) ^ ((x & 32'hFE) << 7) ^ ((x & 32'h1) << 23) ^ ((x & 32'hF8) << 13);
    return a ^ rotl(lin, 8 * bs);
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic ks);
    logic [31:0] acc = a;
    for (int bs = 0; bs < 4; bs++) acc = bs_step(acc, b, bs, ks);
    return acc;
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Issue one request to DUT d and wait (bounded) until out_valid is up
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic ks, input logic wiggle);
    int cyc = 0;
    logic [31:0] exp = ref_model(a, b, ks);
    rs1 = a; rs2 = b; op_ks = ks;
    check_eq("in_ready_before_accept", 32'(in_ready_v[d]), 32'd1);
    in_valid_v[d] = 1'b1;
    tick();
    if (!wiggle) in_valid_v[d] = 1'b0;
    while (!out_valid_v[d] && cyc < 10) begin
      check_eq("in_ready_busy", 32'(in_ready_v[d]), 32'd0);
      if (wiggle) begin
        rs1 = $urandom; rs2 = $urandom; op_ks = ~op_ks;
      end
      tick();
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(4 / lanes_of[d]));
    check_eq("result", result_v[d], exp);
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic ks, input int stall, input logic wiggle);
    logic [31:0] exp = ref_model(a, b, ks);
    issue(d, a, b, ks, wiggle);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("stall_result", result_v[d], exp);
      check_eq("stall_valid", 32'(out_valid_v[d]), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready_v[d]), 32'd0);
    end
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
    in_valid_v[d]  = 1'b0;
    check_eq("post_hs_valid", 32'(out_valid_v[d]), 32'd0);
    check_eq("post_hs_in_ready", 32'(in_ready_v[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    g_reset = 1'b1; flush = 1'b0;
    rs1 = '0; rs2 = '0; op_ks = 1'b0;
    in_valid_v = '0; out_ready_v = '0;
    tick(); tick();
    g_reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_in_ready", 32'(in_ready_v[d]), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid_v[d]), 32'd0);
      check_eq("rst_result", result_v[d], 32'd0);
    end

    // Directed vectors with known answers
    run_op(0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    check_eq("known_ed_l1", result_v[0], 32'h5B5B5B5B);
    run_op(2, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    check_eq("known_ks_l4", result_v[2], 32'h67676767);
    run_op(2, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 1'b0);
    check_eq("known_ks_l4_inv", result_v[2], 32'h98989898);

    // Random requests across all lane counts, with stalls and input wiggle
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 8; n++) begin
        run_op(d, $urandom, $urandom, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end
    end

    // Flush during the second BUSY cycle
    held = result_v[0];
    rs1 = $urandom; rs2 = $urandom; op_ks = 1'b0;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_in_ready", 32'(in_ready_v[0]), 32'd1);
    check_eq("flush_result_held", result_v[0], held);
    for (int k = 0; k < 6; k++) begin
      check_eq("flush_no_valid", 32'(out_valid_v[0]), 32'd0);
      tick();
    end
    // Flush with a request in IDLE drops the request
    in_valid_v[0] = 1'b1; flush = 1'b1;
    tick();
    in_valid_v[0] = 1'b0; flush = 1'b0;
    check_eq("flush_drop_in_ready", 32'(in_ready_v[0]), 32'd1);
    run_op(0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    check_eq("after_flush_known", result_v[0], 32'h5B5B5B5B);

    // Reset while holding a result in DONE
    issue(1, $urandom, $urandom, 1'b1, 1'b0);
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    check_eq("rst_done_valid", 32'(out_valid_v[1]), 32'd0);
    check_eq("rst_done_result", result_v[1], 32'd0);
    check_eq("rst_done_in_ready", 32'(in_ready_v[1]), 32'd1);

    // Reset and flush together behave as reset alone
    issue(1, $urandom, $urandom, 1'b0, 1'b0);
    g_reset = 1'b1; flush = 1'b1;
    tick();
    g_reset = 1'b0; flush = 1'b0;
    check_eq("rstfl_valid", 32'(out_valid_v[1]), 32'd0);
    check_eq("rstfl_result", result_v[1], 32'd0);
    check_eq("rstfl_in_ready", 32'(in_ready_v[1]), 32'd1);

    run_op(1, 32'h0, 32'h0, 1'b0, 2, 1'b1);
    check_eq("after_rst_known", result_v[1], 32'h5B5B5B5B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
